swb_seq: RTL



---
 rtl/swb_seq_pkg.sv | 48 ++++
 rtl/swb_seq_ctrl.sv | 87 ++++++++
 rtl/swb_seq.sv | 109 ++++++++++
 3 files changed

// File: rtl/swb_seq_pkg.sv
// swb_seq_pkg: opcodes, config/instruction types, payload unpack helpers and FSM states for swb_seq.
package swb_seq_pkg;

    localparam logic [2:0] OPCODE_SWB = 3'b100;
    localparam logic [2:0] OPCODE_SEQ = 3'b110;

    typedef struct packed {
        logic [3:0] source;
        logic       en;
    } swb_cfg_t;

    typedef struct packed {
        logic [2:0] option;
        logic [3:0] source;
        logic [3:0] target;
        logic       en;
    } swb_instr_t;

    typedef struct packed {
        logic [2:0]  last_opt;
        logic [23:0] dwell;
        logic [23:0] loops;
    } seq_instr_t;

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic [23:0] field(input logic [23:0] p, input int msb, input int w);
        return (p >> (msb - w + 1)) & ((24'd1 << w) - 24'd1);
    endfunction

    function automatic swb_instr_t unpack_swb(input logic [23:0] p, input int ow, input int sw);
        swb_instr_t r;
        r.option = 3'(field(p, 23, ow));
        r.source = 4'(field(p, 23 - ow, sw));
        r.target = 4'(field(p, 23 - ow - sw, sw));
        r.en     = 1'(field(p, 23 - ow - 2 * sw, 1));
        return r;
    endfunction

    function automatic seq_instr_t unpack_seq(input logic [23:0] p, input int ow, input int dw, input int lw);
        seq_instr_t r;
        r.last_opt = 3'(field(p, 23, ow));
        r.dwell    = field(p, 23 - ow, dw);
        r.loops    = field(p, 23 - ow - dw, lw);
        return r;
    endfunction

endpackage

// File: rtl/swb_seq_ctrl.sv
// swb_seq_ctrl: option sequencer FSM with dwell and loop counters, driving config load strobes.
module swb_seq_ctrl import swb_seq_pkg::*; #(
    parameter int NUM_OPTIONS = 4,
    parameter int DWELL_W     = 8,
    parameter int LOOP_W      = 8,
    localparam int OW         = $clog2(NUM_OPTIONS)
) (
    input  logic          clk_0,
    input  logic          rst_n_0,
    input  logic          i_act,
    input  logic          i_seq_we,
    input  seq_instr_t    i_seq,
    output logic          o_load,
    output logic [OW-1:0] o_load_opt,
    output logic [OW-1:0] o_curr,
    output logic          o_busy
);

    state_t               r_state, w_state;
    logic [OW-1:0]        r_last, r_curr, w_curr;
    logic [DWELL_W-1:0]   r_dwell, r_dcnt, w_dcnt;
    logic [LOOP_W-1:0]    r_loops, r_lcnt, w_lcnt;
    logic                 w_load;

    always_ff @(posedge clk_0 or negedge rst_n_0) begin
        if (!rst_n_0) begin
            r_last  <= '0;
            r_dwell <= '0;
            r_loops <= '0;
        end else if (i_seq_we) begin
            r_last  <= (i_seq.last_opt >= 3'(NUM_OPTIONS - 1)) ? OW'(NUM_OPTIONS - 1) : OW'(i_seq.last_opt);
            r_dwell <= DWELL_W'(i_seq.dwell);
            r_loops <= LOOP_W'(i_seq.loops);
        end
    end

    always_comb begin
        w_state = r_state;
        w_curr  = r_curr;
        w_dcnt  = r_dcnt;
        w_lcnt  = r_lcnt;
        w_load  = 1'b0;
        if (i_act) begin
            w_state = RUN;
            w_curr  = '0;
            w_dcnt  = r_dwell;
            w_lcnt  = r_loops;
            w_load  = 1'b1;
        end else if (r_state == RUN) begin
            if (r_dcnt != '0) begin
                w_dcnt = r_dcnt - DWELL_W'(1);
            end else if (r_curr < r_last) begin
                w_curr = r_curr + OW'(1);
                w_dcnt = r_dwell;
                w_load = 1'b1;
            end else if (r_lcnt == LOOP_W'(1)) begin
                w_state = IDLE;
                w_lcnt  = '0;
            end else begin
                w_curr = '0;
                w_dcnt = r_dwell;
                w_lcnt = (r_lcnt != '0) ? r_lcnt - LOOP_W'(1) : r_lcnt;
                w_load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_0 or negedge rst_n_0) begin
        if (!rst_n_0) begin
            r_state <= IDLE;
            r_curr  <= '0;
            r_dcnt  <= '0;
            r_lcnt  <= '0;
        end else begin
            r_state <= w_state;
            r_curr  <= w_curr;
            r_dcnt  <= w_dcnt;
            r_lcnt  <= w_lcnt;
        end
    end

    assign o_load     = w_load;
    assign o_load_opt = w_curr;
    assign o_curr     = r_curr;
    assign o_busy     = (r_state == RUN);

endmodule

// File: rtl/swb_seq.sv
// swb_seq: sequenced word-channel switchbox with shadow-applied configs; SWB_SEQ_OUT_REG_EN registers all outputs.
module swb_seq import swb_seq_pkg::*; #(
    parameter int NUM_SLOTS            = 16,
    parameter int WORD_BITWIDTH        = 32,
    parameter int NUM_OPTIONS          = 4,
    parameter int DWELL_W              = 8,
    parameter int LOOP_W               = 8,
    parameter int RESOURCE_INSTR_WIDTH = 27,
    localparam int OW                  = $clog2(NUM_OPTIONS),
    localparam int SW                  = $clog2(NUM_SLOTS),
    localparam int BW                  = NUM_SLOTS * WORD_BITWIDTH
) (
    input  logic                            clk_0,
    input  logic                            rst_n_0,
    input  logic                            instr_en_0,
    input  logic [RESOURCE_INSTR_WIDTH-1:0] instr_0,
    input  logic [3:0]                      activate_0,
    input  logic [BW-1:0]                   word_channels_in,
    output logic [BW-1:0]                   word_channels_out,
    output logic                            seq_busy,
    output logic [OW-1:0]                   curr_option
);

    swb_cfg_t                 r_cfg [NUM_OPTIONS][NUM_SLOTS];
    swb_cfg_t                 r_app [NUM_SLOTS];
    swb_instr_t               w_swb;
    seq_instr_t               w_seq;
    logic [2:0]               w_opcode;
    logic                     w_swb_we, w_seq_we, w_load, w_busy, w_unused;
    logic [OW-1:0]            w_load_opt, w_curr;
    logic [WORD_BITWIDTH-1:0] w_in [NUM_SLOTS];
    logic [BW-1:0]            w_out;

    assign w_opcode = instr_0[RESOURCE_INSTR_WIDTH-1 -: 3];
    assign w_swb    = unpack_swb(instr_0[23:0], OW, SW);
    assign w_seq    = unpack_seq(instr_0[23:0], OW, DWELL_W, LOOP_W);
    assign w_swb_we = instr_en_0 && (w_opcode == OPCODE_SWB);
    assign w_seq_we = instr_en_0 && (w_opcode == OPCODE_SEQ);
    assign w_unused = ^activate_0[3:1];

    swb_seq_ctrl #(
        .NUM_OPTIONS (NUM_OPTIONS),
        .DWELL_W     (DWELL_W),
        .LOOP_W      (LOOP_W)
    ) u_ctrl (
        .clk_0      (clk_0),
        .rst_n_0    (rst_n_0),
        .i_act      (activate_0[0]),
        .i_seq_we   (w_seq_we),
        .i_seq      (w_seq),
        .o_load     (w_load),
        .o_load_opt (w_load_opt),
        .o_curr     (w_curr),
        .o_busy     (w_busy)
    );

    always_ff @(posedge clk_0 or negedge rst_n_0) begin
        if (!rst_n_0) begin
            for (int o = 0; o < NUM_OPTIONS; o++)
                for (int t = 0; t < NUM_SLOTS; t++)
                    r_cfg[o][t] <= '0;
        end else if (w_swb_we) begin
            r_cfg[OW'(w_swb.option)][SW'(w_swb.target)] <= {w_swb.source, w_swb.en};
        end
    end

    // Nonblocking read gives the pre-write value when a write hits the option being loaded.
    always_ff @(posedge clk_0 or negedge rst_n_0) begin
        if (!rst_n_0) begin
            for (int t = 0; t < NUM_SLOTS; t++)
                r_app[t] <= '0;
        end else if (w_load) begin
            for (int t = 0; t < NUM_SLOTS; t++)
                r_app[t] <= r_cfg[w_load_opt][t];
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_xbar
        assign w_in[i] = word_channels_in[i*WORD_BITWIDTH +: WORD_BITWIDTH];
        assign w_out[i*WORD_BITWIDTH +: WORD_BITWIDTH] = r_app[i].en ? w_in[r_app[i].source[SW-1:0]] : '0;
    end

`ifdef SWB_SEQ_OUT_REG_EN
    logic [BW-1:0] r_out;
    logic          r_busy;
    logic [OW-1:0] r_curr;

    always_ff @(posedge clk_0 or negedge rst_n_0) begin
        if (!rst_n_0) begin
            r_out  <= '0;
            r_busy <= 1'b0;
            r_curr <= '0;
        end else begin
            r_out  <= w_out;
            r_busy <= w_busy;
            r_curr <= w_curr;
        end
    end

    assign word_channels_out = r_out;
    assign seq_busy          = r_busy;
    assign curr_option       = r_curr;
`else
    assign word_channels_out = w_out;
    assign seq_busy          = w_busy;
    assign curr_option       = w_curr;
`endif

endmodule
